id_ex_skid_reg: RTL and testbench
=================================

Name: id_ex_skid_reg

Overview:
Parametrised successor to the ID→EX pipeline register. It carries instruction and PC between decode and execute with a valid/ready handshake and a 2-entry skid buffer, so backpressure never drops a beat. It also supports synchronous flush (bubble insertion) and saturating stall/flush performance counters. Sits between the ID stage and the EX stage; the same block is reusable at other stage boundaries by width.

Parameters:
INSTR_W, 32, instruction width
PC_W, 32, PC width
NOP_INSTR, {INSTR_W{1'b0}}, value driven on instr_out when holding a bubble
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream beat present
in_ready  output  1  block can accept a beat (registered)
instr_in  input  INSTR_W  upstream instruction
pc_in  input  PC_W  upstream PC
flush  input  1  synchronous flush request, highest priority
out_valid  output  1  main register holds a valid beat
out_ready  input  1  downstream accepts a beat
instr_out  output  INSTR_W  main register instruction
pc_out  output  PC_W  main register PC
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
flush_cnt  output  CNT_W  cycles with flush=1, saturating

Behaviour:
- State: main {valid, instr, pc} and skid {valid, instr, pc}. Outputs are driven directly from main; in_ready = !skid.valid, registered.
- Reset (reset=0, async): main.valid=0, skid.valid=0, instr_out=NOP_INSTR, pc_out=0, in_ready=1, stall_cnt=0, flush_cnt=0.
- Definitions: acc = in_valid & in_ready; drain = out_valid & out_ready.
- flush=1 takes priority over everything else:
  - main.valid=0 and skid.valid=0; main data becomes NOP_INSTR/0.
  - A beat presented in the same cycle is discarded, even if acc=1.
  - in_ready=1 on the next cycle.
- Otherwise, per cycle:
  - Main empty, or drain=1 with skid empty: if acc, main ← input. Otherwise main.valid=0 and main data becomes NOP_INSTR/0.
  - drain=1 with skid full: main ← skid. If acc, skid ← input; otherwise skid.valid=0. (acc cannot normally occur here because in_ready=0; it is included only for completeness.)
  - Main full, drain=0: if acc, skid ← input and skid.valid=1. Main holds.
- Latency: 1 cycle from acceptance to out_valid while empty.
- Throughput: 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO order. No duplication or loss except via flush.
- in_ready falls the cycle after the skid fills and rises the cycle after the skid empties.
- While out_valid=0, instr_out=NOP_INSTR and pc_out=0 (bubble visible to EX).
- stall_cnt: +1 on each cycle with out_valid & !out_ready; holds at 2^CNT_W-1.
- flush_cnt: +1 on each cycle with flush=1; holds at 2^CNT_W-1.
- Counters are cleared only by reset.
- Reset asserted mid-transfer clears all state immediately, without waiting for clk. The first accept after reset deassertion behaves as from empty.

Test Plan:
1. Reset: hold reset=0 with random inputs → out_valid=0, in_ready=1, instr_out=NOP_INSTR, pc_out=0, counters=0.
2. Streaming: out_ready=1; send instr 0x11,0x22,0x33 with pc 0x0,0x4,0x8 on back-to-back cycles → same values appear on instr_out/pc_out one cycle later each, out_valid high for exactly 3 cycles.
3. Backpressure: out_ready=0; send 0xA1 then 0xA2 → main=0xA1, skid=0xA2, in_ready=0 next cycle. Further in_valid beats are not accepted. Raise out_ready → output 0xA1 then 0xA2, in_ready returns to 1. stall_cnt equals the number of stalled valid cycles.
4. Flush with skid full: from state of scenario 3, assert flush together with in_valid carrying 0xB0 → next cycle out_valid=0, instr_out=NOP_INSTR, in_ready=1, flush_cnt=1. 0xB0 never appears at the output.
5. Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays 15.
6. Async reset mid-operation: skid full, drop reset between clock edges → outputs reach reset values before the next rising edge. A subsequent beat 0xC0 appears one cycle after acceptance.

Source files
------------

// File: rtl/id_ex_skid_reg.sv
// ID->EX pipeline register with a 2-entry skid buffer, flush and
// saturating stall/flush counters.
module id_ex_skid_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef struct packed {
    logic               v;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } slot_t;

  localparam slot_t BUBBLE = '{
    v:     1'b0,
    instr: NOP_INSTR,
    pc:    {PC_W{1'b0}}
  };

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_t main_q, main_d;
  slot_t skid_q, skid_d;
  slot_t in_s;

  logic acc, drain;
  logic do_load, do_shift, do_hold;

  logic [CNT_W-1:0] stall_q, flush_q;

  assign in_s      = '{v: 1'b1, instr: instr_in, pc: pc_in};
  assign in_ready  = ~skid_q.v;
  assign out_valid = main_q.v;
  assign instr_out = main_q.instr;
  assign pc_out    = main_q.pc;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  assign acc   = in_valid & in_ready;
  assign drain = main_q.v & out_ready;

  // Mutually exclusive so the decoder below stays one-hot.
  assign do_load  = ~flush & (~main_q.v | (drain & ~skid_q.v));
  assign do_shift = ~flush & drain & skid_q.v;
  assign do_hold  = ~flush & main_q.v & ~drain;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    unique case (1'b1)
      flush: begin
        main_d = BUBBLE;
        skid_d = BUBBLE;
      end
      do_load: begin
        main_d = acc ? in_s : BUBBLE;
      end
      do_shift: begin
        main_d = skid_q;
        skid_d = acc ? in_s : BUBBLE;
      end
      do_hold: begin
        if (acc) skid_d = in_s;
      end
      default: begin
        main_d = main_q;
        skid_d = skid_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_q.v && !out_ready && stall_q != CNT_MAX)
        stall_q <= stall_q + CNT_W'(1);
      if (flush && flush_q != CNT_MAX)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Scoreboard bench for id_ex_skid_reg: queue-based occupancy model,
// decoupled monitor comparing every drained beat.
module tb_id_ex_skid_reg;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          CMAX = 15;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;

  id_ex_skid_reg #(
    .INSTR_W  (32),
    .PC_W     (32),
    .NOP_INSTR(NOP),
    .CNT_W    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr_in (instr_in),
    .pc_in    (pc_in),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .instr_out(instr_out),
    .pc_out   (pc_out),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb[$];
  int occ     = 0;
  int stall_m = 0;
  int flush_m = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endfunction

  // Monitor: every beat taken downstream must be the oldest pending one.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got %h/%h want none",
                   instr_out, pc_out);
        end else begin
          exp = sb.pop_front();
          chk("instr_out", instr_out, exp[63:32]);
          chk("pc_out", pc_out, exp[31:0]);
        end
      end
    end
  end

  task automatic check_state();
    chk("in_ready", {31'b0, in_ready}, {31'b0, occ < 2});
    chk("out_valid", {31'b0, out_valid}, {31'b0, occ > 0});
    if (occ == 0) begin
      chk("bubble_instr", instr_out, NOP);
      chk("bubble_pc", pc_out, 32'h0);
    end
    chk("stall_cnt", {28'b0, stall_cnt}, stall_m);
    chk("flush_cnt", {28'b0, flush_cnt}, flush_m);
  endtask

  task automatic step(input bit iv, input logic [31:0] ins,
                      input logic [31:0] pc, input bit ordy,
                      input bit fl);
    bit acc, drn;
    @(negedge clk);
    in_valid  = iv;
    instr_in  = ins;
    pc_in     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_state();
    acc = iv && occ < 2;
    drn = occ > 0 && ordy;
    if (occ > 0 && !ordy && stall_m < CMAX) stall_m++;
    if (fl && flush_m < CMAX) flush_m++;
    #2;
    if (fl) begin
      sb.delete();
      occ = 0;
    end else begin
      occ = occ - int'(drn) + int'(acc);
      if (acc) sb.push_back({ins, pc});
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, $urandom, $urandom, ordy, 1'b0);
  endtask

  // Reset dropped between edges; outputs must clear before the next edge.
  task automatic async_rst();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    occ     = 0;
    stall_m = 0;
    flush_m = 0;
    sb.delete();
    check_state();
    @(negedge clk);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int spin;
    reset     = 1'b0;
    in_valid  = 1'b0;
    instr_in  = '0;
    pc_in     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      instr_in  = $urandom;
      pc_in     = $urandom;
      out_ready = 1'($urandom);
      flush     = 1'($urandom);
      #1;
      check_state();
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #3;
    reset = 1'b1;

    // Streaming
    step(1'b1, 32'h11, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h22, 32'h4, 1'b1, 1'b0);
    step(1'b1, 32'h33, 32'h8, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Backpressure, then drain
    async_rst();
    step(1'b1, 32'hA1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'hA3, 32'h108, 1'b0, 1'b0);
    step(1'b1, 32'hA4, 32'h10C, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with skid full and a beat presented
    step(1'b1, 32'hD1, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'hD2, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'hB0, 32'h208, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Counter saturation
    async_rst();
    step(1'b1, 32'hE1, 32'h300, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    idle(1'b1);

    // Async reset with skid full, then a fresh beat
    step(1'b1, 32'hF1, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'hF2, 32'h404, 1'b0, 1'b0);
    async_rst();
    step(1'b1, 32'hC0, 32'h500, 1'b1, 1'b0);
    idle(1'b1);

    // Random traffic
    async_rst();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), $urandom, $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    // Drain whatever is left, bounded
    spin = 0;
    while (occ > 0 && spin < 10) begin
      idle(1'b1);
      spin++;
    end
    idle(1'b1);
    chk("leftover", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
